// File: rtl/dot_product_slave.sv
// dot_product_slave: buffers element pairs, runs a sequential unsigned MAC,
// stores the result into a small register file and serves read-back.
module dot_product_slave #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wdvalid,
    input  logic              awvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic [DATA_W-1:0] waddr_a,
    input  logic [DATA_W-1:0] waddr_b,
    input  logic [DATA_W-1:0] waddr_output,
    input  logic [DATA_W-1:0] vector_len,
    input  logic              start_compute,
    input  logic              start_write,
    input  logic              start_read,
    input  logic [DATA_W-1:0] read_addr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              processing_done,
    output logic              store_done,
    output logic              read_done,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, STORE, READ} state_t;

    state_t            state, nxt_state, ret_state, nxt_ret;
    logic [CW-1:0]     wr_cnt, nxt_cnt, n_cnt, nxt_n, idx;
    logic [DATA_W-1:0] len_r, nxt_len, addr_a_r, addr_b_r, addr_out_r, result;
    logic [ACC_W-1:0]  acc, prod;
    logic [DATA_W-1:0] buf_a [DEPTH];
    logic [DATA_W-1:0] buf_b [DEPTH];
    logic [DATA_W-1:0] outmem [DEPTH];
    logic              idle_load, beat, first;

    // A beat landing in the same cycle as a start is counted before N is fixed.
    always_comb begin
        idle_load = state == IDLE || state == LOAD;
        beat      = wdvalid && awvalid && wready;
        first     = beat && wr_cnt == '0;
        nxt_len   = first ? vector_len : len_r;
        nxt_cnt   = beat ? wr_cnt + 1'b1 : wr_cnt;
        nxt_state = beat ? LOAD : state;
        nxt_ret   = ret_state;
        if (idle_load) begin
            nxt_ret = nxt_state;
            if (start_compute) nxt_state = COMPUTE;
            else if (start_write) nxt_state = STORE;
            else if (start_read) nxt_state = READ;
        end else if (state == COMPUTE && idx == n_cnt) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else if (state == STORE || state == READ) begin
            nxt_state = ret_state;
        end
        nxt_n = (nxt_len < DATA_W'(nxt_cnt)) ? CW'(nxt_len) : nxt_cnt;
        prod  = ACC_W'(buf_a[idx[AW-1:0]]) * ACC_W'(buf_b[idx[AW-1:0]]);
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            buf_a[wr_cnt[AW-1:0]] <= wdata_a;
            buf_b[wr_cnt[AW-1:0]] <= wdata_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ret_state       <= IDLE;
            wr_cnt          <= '0;
            n_cnt           <= '0;
            idx             <= '0;
            len_r           <= '0;
            addr_a_r        <= '0;
            addr_b_r        <= '0;
            addr_out_r      <= '0;
            acc             <= '0;
            result          <= '0;
            rdata           <= '0;
            rvalid          <= 1'b0;
            wready          <= 1'b0;
            busy            <= 1'b0;
            processing_done <= 1'b0;
            store_done      <= 1'b0;
            read_done       <= 1'b0;
            overflow        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) outmem[i] <= '0;
        end else begin
            state           <= nxt_state;
            ret_state       <= nxt_ret;
            wr_cnt          <= nxt_cnt;
            len_r           <= nxt_len;
            wready          <= (nxt_state == IDLE || nxt_state == LOAD) && nxt_cnt < CW'(DEPTH);
            busy            <= nxt_state == COMPUTE || nxt_state == STORE || nxt_state == READ;
            processing_done <= 1'b0;
            store_done      <= 1'b0;
            rvalid          <= 1'b0;
            read_done       <= 1'b0;
            if (first) begin
                addr_a_r   <= waddr_a;
                addr_b_r   <= waddr_b;
                addr_out_r <= waddr_output;
            end
            if (idle_load && nxt_state == COMPUTE) begin
                acc   <= '0;
                idx   <= '0;
                n_cnt <= nxt_n;
            end
            if (state == COMPUTE) begin
                if (idx != n_cnt) begin
                    acc <= acc + prod;
                    idx <= idx + 1'b1;
                end else begin
                    result          <= acc[DATA_W-1:0];
                    overflow        <= |acc[ACC_W-1:DATA_W];
                    processing_done <= 1'b1;
                end
            end
            if (state == STORE) begin
                outmem[addr_out_r[AW-1:0]] <= result;
                store_done                 <= 1'b1;
            end
            if (state == READ) begin
                rdata     <= outmem[read_addr[AW-1:0]];
                rvalid    <= 1'b1;
                read_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_slave.sv
// tb_dot_product_slave: table-driven load/compute/store/read vectors with a
// read-data scoreboard, plus hand sequences for overflow, arbitration and reset.
module tb_dot_product_slave;
    localparam int DW = 32;
    localparam int D  = 16;

    logic          clk = 1'b0, rst = 1'b0;
    logic          wdvalid = 0, awvalid = 0, wready;
    logic [DW-1:0] wdata_a = 0, wdata_b = 0, waddr_a = 0, waddr_b = 0;
    logic [DW-1:0] waddr_output = 0, vector_len = 0, read_addr = 0, rdata;
    logic          start_compute = 0, start_write = 0, start_read = 0;
    logic          rvalid, busy, processing_done, store_done, read_done, overflow;

    always #5 clk = ~clk;

    dot_product_slave #(.DATA_W(DW), .DEPTH(D), .ACC_W(64)) dut (
        .clk(clk), .rst(rst), .wdvalid(wdvalid), .awvalid(awvalid), .wready(wready),
        .wdata_a(wdata_a), .wdata_b(wdata_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
        .waddr_output(waddr_output), .vector_len(vector_len),
        .start_compute(start_compute), .start_write(start_write), .start_read(start_read),
        .read_addr(read_addr), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .processing_done(processing_done), .store_done(store_done),
        .read_done(read_done), .overflow(overflow)
    );

    int checks = 0, errors = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        int                 n;
        logic [0:3][DW-1:0] a;
        logic [0:3][DW-1:0] b;
        logic [DW-1:0]      len, addr, raddr, res;
        logic               ovf;
        int                 lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int n, input logic [0:3][DW-1:0] a, input logic [0:3][DW-1:0] b,
                        input logic [DW-1:0] len, input logic [DW-1:0] addr);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            @(negedge clk);
            wdvalid = 1; awvalid = 1;
            wdata_a = a[i]; wdata_b = b[i];
            waddr_a = 32'h1000 + i; waddr_b = 32'h2000 + i;
            vector_len = len; waddr_output = addr;
            while (!wready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) check("wready_wait", {63'd0, wready}, 1);
        end
        @(negedge clk);
        wdvalid = 0; awvalid = 0;
    endtask

    task automatic compute(input logic ovf, input int lat, input string nm);
        int c = 0;
        @(negedge clk);
        start_compute = 1;
        @(negedge clk);
        start_compute = 0;
        while (!processing_done && c < 64) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_latency"}, c, lat);
        check({nm, "_overflow"}, {63'd0, overflow}, {63'd0, ovf});
        @(negedge clk);
        check({nm, "_done_pulse"}, {63'd0, processing_done}, 0);
    endtask

    task automatic store(input string nm);
        @(negedge clk);
        start_write = 1;
        @(negedge clk);
        start_write = 0;
        check({nm, "_store_busy"}, {63'd0, busy}, 1);
        @(negedge clk);
        check({nm, "_store_done"}, {63'd0, store_done}, 1);
    endtask

    task automatic rd(input logic [DW-1:0] addr, input logic [DW-1:0] exp, input string nm);
        int c = 0;
        logic [DW-1:0] e;
        @(negedge clk);
        start_read = 1;
        read_addr = addr;
        sb.push_back(exp);
        @(negedge clk);
        start_read = 0;
        while (!rvalid && c < 8) begin
            @(negedge clk);
            c++;
        end
        e = sb.pop_front();
        check({nm, "_read_lat"}, c, 1);
        check({nm, "_read_done"}, {63'd0, read_done}, 1);
        check({nm, "_rdata"}, {32'd0, rdata}, {32'd0, e});
        @(negedge clk);
        check({nm, "_rvalid_pulse"}, {63'd0, rvalid}, 0);
        check({nm, "_rdata_hold"}, {32'd0, rdata}, {32'd0, e});
    endtask

    initial begin
        int acc_cnt, seen, c;
        vecs[0] = '{n:4, a:{32'd3, 32'd5, 32'd6, 32'd3}, b:{32'd2, 32'd4, 32'd7, 32'd8},
                    len:15, addr:15, raddr:15, res:92, ovf:0, lat:5};
        vecs[1] = '{n:3, a:{32'd3, 32'd15, 32'd9, 32'd0}, b:{32'd5, 32'd7, 32'd3, 32'd0},
                    len:2, addr:32'h25, raddr:32'h35, res:120, ovf:0, lat:3};
        vecs[2] = '{n:2, a:{32'h10000, 32'h10000, 32'd0, 32'd0}, b:{32'h10000, 32'h10000, 32'd0, 32'd0},
                    len:2, addr:3, raddr:3, res:0, ovf:1, lat:3};
        vecs[3] = '{n:1, a:{32'd1, 32'd0, 32'd0, 32'd0}, b:{32'd1, 32'd0, 32'd0, 32'd0},
                    len:1, addr:4, raddr:4, res:1, ovf:0, lat:2};
        vecs[4] = '{n:2, a:{32'd7, 32'd100, 32'd0, 32'd0}, b:{32'd6, 32'd200, 32'd0, 32'd0},
                    len:5, addr:8, raddr:8, res:20042, ovf:0, lat:3};

        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, wready, rvalid, busy, processing_done, store_done,
                                read_done, overflow, rdata}, 0);
        rst = 1;

        foreach (vecs[i]) begin
            string nm = $sformatf("vec%0d", i);
            load(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].len, vecs[i].addr);
            compute(vecs[i].ovf, vecs[i].lat, nm);
            store(nm);
            rd(vecs[i].raddr, vecs[i].res, nm);
        end

        // 17 back-to-back beats: only DEPTH accepted, then compute with length 0
        acc_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wdvalid = 1; awvalid = 1;
            wdata_a = i + 1; wdata_b = i + 2;
            vector_len = 0; waddr_output = 8;
            if (wready) acc_cnt++;
        end
        @(negedge clk);
        wdvalid = 0; awvalid = 0;
        check("full_accepted", acc_cnt, 16);
        check("full_wready_low", {63'd0, wready}, 0);
        compute(0, 1, "len0");
        store("len0");
        rd(8, 0, "len0");
        check("wready_after_clear", {63'd0, wready}, 1);

        // simultaneous starts, then a read request while computing
        load(1, {32'hFFFFFFFF, 32'd0, 32'd0, 32'd0}, {32'hFFFFFFFF, 32'd0, 32'd0, 32'd0}, 1, 6);
        @(negedge clk);
        start_compute = 1; start_write = 1; start_read = 1; read_addr = 6;
        @(negedge clk);
        start_compute = 0; start_write = 0;
        check("arb_busy", {63'd0, busy}, 1);
        @(negedge clk);
        start_read = 0;
        seen = 0;
        c = 1;
        while (!processing_done && c < 20) begin
            seen |= int'(store_done | read_done);
            @(negedge clk);
            c++;
        end
        check("arb_latency", c, 2);
        check("arb_overflow", {63'd0, overflow}, 1);
        repeat (4) begin
            @(negedge clk);
            seen |= int'(store_done | read_done);
        end
        check("arb_losers_dropped", seen, 0);

        // asynchronous reset in the middle of a compute
        load(4, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 4, 0);
        @(negedge clk);
        start_compute = 1;
        @(negedge clk);
        start_compute = 0;
        check("midrst_busy", {63'd0, busy}, 1);
        #2 rst = 0;
        #1 check("midrst_outputs", {25'd0, wready, rvalid, busy, processing_done, store_done,
                                     read_done, overflow, rdata}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= int'(processing_done);
        end
        check("midrst_no_done", seen, 0);
        for (int a = 0; a < D; a++) rd(a, 0, $sformatf("clr%0d", a));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
